// File: rtl/param_register_file_if.sv
// Register-file bus: three combinational read ports, two write ports and PC control.
// The datapath side uses the master modport; the register file uses the slave modport.
interface param_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rc;
    logic [DATA_W-1:0] puerto_a;
    logic [DATA_W-1:0] puerto_b;
    logic [DATA_W-1:0] puerto_c;
    logic [ADDR_W-1:0] rw0;
    logic [DATA_W-1:0] pw0;
    logic              le0;
    logic [ADDR_W-1:0] rw1;
    logic [DATA_W-1:0] pw1;
    logic              le1;
    logic [DATA_W-1:0] pc_in;
    logic              pc_ld;
    logic              pc_inc;
    logic [DATA_W-1:0] pc_out;

    modport master (
        output ra, rb, rc, rw0, pw0, le0, rw1, pw1, le1, pc_in, pc_ld, pc_inc,
        input  puerto_a, puerto_b, puerto_c, pc_out
    );

    modport slave (
        input  ra, rb, rc, rw0, pw0, le0, rw1, pw1, le1, pc_in, pc_ld, pc_inc,
        output puerto_a, puerto_b, puerto_c, pc_out
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file, 3 read / 2 write ports, top register is the PC.
// Optional macro PARAM_RF_WRITE_BYPASS_EN forwards same-cycle write results to the read ports.

// Next-state for one general-purpose register: W0 beats W1 on a shared index.
module param_rf_cell #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int IDX    = 0
) (
    input  logic [DATA_W-1:0] q_i,
    input  logic              le0_i,
    input  logic [ADDR_W-1:0] rw0_i,
    input  logic [DATA_W-1:0] pw0_i,
    input  logic              le1_i,
    input  logic [ADDR_W-1:0] rw1_i,
    input  logic [DATA_W-1:0] pw1_i,
    output logic [DATA_W-1:0] d_o
);
    localparam logic [ADDR_W-1:0] MY_IDX = ADDR_W'(IDX);

    always_comb begin
        d_o = q_i;
        if (le0_i && rw0_i == MY_IDX)      d_o = pw0_i;
        else if (le1_i && rw1_i == MY_IDX) d_o = pw1_i;
    end
endmodule

module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    param_register_file_if.slave   bus
);
    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

    logic [NREGS-1:0][DATA_W-1:0] rf_q, rf_d, rd_src;
    logic [NREGS-2:0][DATA_W-1:0] cell_d;
    logic [DATA_W-1:0]            pc_q, pc_d;

    assign pc_q = rf_q[NREGS-1];

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_cell
        param_rf_cell #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .IDX    (i)
        ) u_cell (
            .q_i   (rf_q[i]),
            .le0_i (bus.le0),
            .rw0_i (bus.rw0),
            .pw0_i (bus.pw0),
            .le1_i (bus.le1),
            .rw1_i (bus.rw1),
            .pw1_i (bus.pw1),
            .d_o   (cell_d[i])
        );
    end

    // PC priority: W0, W1, external load, increment, hold. Increment wraps modulo 2**DATA_W.
    always_comb begin
        pc_d = pc_q;
        if (bus.le0 && bus.rw0 == PC_IDX)      pc_d = bus.pw0;
        else if (bus.le1 && bus.rw1 == PC_IDX) pc_d = bus.pw1;
        else if (bus.pc_ld)                    pc_d = bus.pc_in;
        else if (bus.pc_inc)                   pc_d = pc_q + DATA_W'(PC_INC);
    end

    always_comb begin
        rf_d = {pc_d, cell_d};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rf_q            <= '0;
            rf_q[NREGS-1]   <= DATA_W'(RESET_PC);
        end else begin
            rf_q <= rf_d;
        end
    end

`ifdef PARAM_RF_WRITE_BYPASS_EN
    // Next-state already encodes W0-over-W1 and the full PC priority, so it is the forwarded value.
    assign rd_src = rf_d;
`else
    assign rd_src = rf_q;
`endif

    assign bus.puerto_a = rd_src[bus.ra];
    assign bus.puerto_b = rd_src[bus.rb];
    assign bus.puerto_c = rd_src[bus.rc];
    assign bus.pc_out   = pc_q;
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: table of single-edge vectors plus hand sequences
// for reset, fill sweep and same-cycle read behaviour.
module tb_param_register_file;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int PC_INC   = 4;
    localparam int RESET_PC = 32'h100;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    param_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    param_register_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        le0;
        logic [3:0]  rw0;
        logic [31:0] pw0;
        logic        le1;
        logic [3:0]  rw1;
        logic [31:0] pw1;
        logic        pc_ld;
        logic [31:0] pc_in;
        logic        pc_inc;
        logic [3:0]  ra, rb, rc;
        logic [31:0] ea, eb, ec, epc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        bus.le0    = 1'b0;  bus.rw0 = '0; bus.pw0 = '0;
        bus.le1    = 1'b0;  bus.rw1 = '0; bus.pw1 = '0;
        bus.pc_ld  = 1'b0;  bus.pc_in = '0;
        bus.pc_inc = 1'b0;
    endtask

    // Drive v for one rising edge, then quiesce writes and compare the chosen reads.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst;
        bus.le0 = v.le0; bus.rw0 = v.rw0; bus.pw0 = v.pw0;
        bus.le1 = v.le1; bus.rw1 = v.rw1; bus.pw1 = v.pw1;
        bus.pc_ld = v.pc_ld; bus.pc_in = v.pc_in; bus.pc_inc = v.pc_inc;
        @(posedge clk);
        #1;
        idle_inputs();
        bus.ra = v.ra; bus.rb = v.rb; bus.rc = v.rc;
        #1;
        check({name, ".a"},  bus.puerto_a, v.ea);
        check({name, ".b"},  bus.puerto_b, v.eb);
        check({name, ".c"},  bus.puerto_c, v.ec);
        check({name, ".pc"}, bus.pc_out,   v.epc);
    endtask

    function automatic vec_t mk(
        input logic rst_, input logic le0, input logic [3:0] rw0, input logic [31:0] pw0,
        input logic le1, input logic [3:0] rw1, input logic [31:0] pw1,
        input logic pc_ld, input logic [31:0] pc_in, input logic pc_inc,
        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec, input logic [31:0] epc);
        vec_t v;
        v.rst = rst_; v.le0 = le0; v.rw0 = rw0; v.pw0 = pw0;
        v.le1 = le1; v.rw1 = rw1; v.pw1 = pw1;
        v.pc_ld = pc_ld; v.pc_in = pc_in; v.pc_inc = pc_inc;
        v.ra = ra; v.rb = rb; v.rc = rc;
        v.ea = ea; v.eb = eb; v.ec = ec; v.epc = epc;
        return v;
    endfunction

    initial begin
        vec_t v;
        // Vectors run after the fill sequence, so R0..R14 start at index*0x11, PC at 0x100.
        vecs.push_back(mk(0, 1,  2, 32'hAAAA, 1,  7, 32'hBBBB, 0, 0, 0,  2, 7, 5, 32'hAAAA, 32'hBBBB, 32'h55, 32'h100));
        vecs.push_back(mk(0, 1,  4, 32'h1,    1,  4, 32'h2,    0, 0, 0,  4, 7, 3, 32'h1, 32'hBBBB, 32'h33, 32'h100));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        0, 0, 1, 15, 4, 14, 32'h104, 32'h1, 32'hEE, 32'h104));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        1, 32'h200, 1, 15, 15, 15, 32'h200, 32'h200, 32'h200, 32'h200));
        vecs.push_back(mk(0, 0,  0, 0,        1, 15, 32'h300,  1, 32'h500, 0, 15, 2, 7, 32'h300, 32'hAAAA, 32'hBBBB, 32'h300));
        vecs.push_back(mk(0, 1, 15, 32'h400,  1, 15, 32'h600,  1, 32'h500, 1, 15, 0, 1, 32'h400, 32'h0, 32'h11, 32'h400));
        vecs.push_back(mk(0, 1, 15, 32'h700,  1,  8, 32'h88,   0, 0, 1,  8, 15, 9, 32'h88, 32'h700, 32'h99, 32'h700));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        0, 0, 0,  8, 15, 4, 32'h88, 32'h700, 32'h1, 32'h700));
        vecs.push_back(mk(0, 1,  3, 32'h3333, 1, 15, 32'h900,  0, 0, 1,  3, 15, 6, 32'h3333, 32'h900, 32'h66, 32'h900));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        1, 32'hFFFFFFFC, 0, 15, 3, 3, 32'hFFFFFFFC, 32'h3333, 32'h3333, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        0, 0, 1, 15, 1, 2, 32'h0, 32'h11, 32'hAAAA, 32'h0));
        vecs.push_back(mk(0, 0,  0, 0,        0,  0, 0,        0, 0, 1, 15, 1, 2, 32'h4, 32'h11, 32'hAAAA, 32'h4));
        vecs.push_back(mk(0, 0,  1, 32'hDEAD, 0, 15, 32'hBEEF, 0, 32'h77, 0, 1, 15, 10, 32'h11, 32'h4, 32'hAA, 32'h4));
        vecs.push_back(mk(1, 1,  1, 32'h5,    1, 15, 32'h9,    1, 32'h50, 1, 1, 2, 15, 32'h0, 32'h0, 32'h100, 32'h100));

        idle_inputs();
        bus.ra = '0; bus.rb = '0; bus.rc = '0;

        // Reset with a simultaneous W0 write that must be discarded.
        rst = 1'b1;
        @(posedge clk);
        v = mk(1, 1, 3, 32'hDEAD, 0, 0, 0, 0, 0, 0, 3, 0, 15, 32'h0, 32'h0, 32'h100, 32'h100);
        apply(v, "reset");

        // Fill R0..R14; each value visible right after its edge, next register still at reset value.
        for (int k = 0; k < 15; k++) begin
            v = mk(0, 1, 4'(k), 32'(k * 32'h11), 0, 0, 0, 0, 0, 0,
                   4'(k), 4'(k + 1), 4'(k), 32'(k * 32'h11), (k < 14) ? 32'h0 : 32'h100,
                   32'(k * 32'h11), 32'h100);
            apply(v, $sformatf("fill%0d", k));
        end
        bus.ra = 4'd5; bus.rb = 4'd14; bus.rc = 4'd10;
        #1;
        check("sweep.r5",  bus.puerto_a, 32'h55);
        check("sweep.r14", bus.puerto_b, 32'hEE);
        check("sweep.r10", bus.puerto_c, 32'hAA);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Same-cycle read of a register and of the PC while they are being updated.
        @(negedge clk);
        bus.le0 = 1'b1; bus.rw0 = 4'd9; bus.pw0 = 32'h1234;
        bus.pc_inc = 1'b1;
        bus.ra = 4'd9; bus.rb = 4'd15; bus.rc = 4'd9;
        #1;
`ifdef PARAM_RF_WRITE_BYPASS_EN
        check("byp.a",  bus.puerto_a, 32'h1234);
        check("byp.pc", bus.puerto_b, 32'h104);
`else
        check("byp.a",  bus.puerto_a, 32'h0);
        check("byp.pc", bus.puerto_b, 32'h100);
`endif
        check("byp.pcout", bus.pc_out, 32'h100);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("post.a",     bus.puerto_a, 32'h1234);
        check("post.pc",    bus.puerto_b, 32'h104);
        check("post.pcout", bus.pc_out,   32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the 16x32 single-write register file in the CPU datapath.
- Generalised width and depth; three combinational read ports; two write ports (W0 for ALU/load result, W1 for base-register writeback on pre/post-indexed load/store).
- Top register doubles as PC, with external load and a built-in auto-increment.
- Sits between decode and execute; PC output feeds instruction memory.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register index width; NREGS = 2**ADDR_W; PC is register NREGS-1.
- PC_INC, 4, amount added to PC on pc_inc.
- RESET_PC, 0, PC value after reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ra  in  ADDR_W  read select, port A.
- rb  in  ADDR_W  read select, port B.
- rc  in  ADDR_W  read select, port C (store data / shift amount).
- puerto_a  out  DATA_W  contents of register ra.
- puerto_b  out  DATA_W  contents of register rb.
- puerto_c  out  DATA_W  contents of register rc.
- rw0  in  ADDR_W  write select, port W0.
- pw0  in  DATA_W  write data, port W0.
- le0  in  1  write enable, port W0.
- rw1  in  ADDR_W  write select, port W1.
- pw1  in  DATA_W  write data, port W1.
- le1  in  1  write enable, port W1.
- pc_in  in  DATA_W  external PC value (branch target).
- pc_ld  in  1  load pc_in into PC.
- pc_inc  in  1  PC <= PC + PC_INC.
- pc_out  out  DATA_W  current PC (register NREGS-1), always driven.

Behaviour:
- Reset (sampled at Clk edge): all registers 0 except PC = RESET_PC. Reset overrides every write and PC request in that cycle.
- Post-reset outputs: puerto_a/b/c = 0 for any non-PC select, RESET_PC for PC select; pc_out = RESET_PC.
- Reads: purely combinational mux of current register contents, zero-cycle latency. Any index is legal, including the PC index (returns PC).
- Writes: registered, one-cycle latency; new value is visible on outputs after the edge.
- Same-register collision, rw0 == rw1 with both enables high: W0 wins, W1 is dropped for that register.
- PC update priority per edge, highest first:
  1. le0 with rw0 == PC -> pw0
  2. le1 with rw1 == PC -> pw1
  3. pc_ld -> pc_in
  4. pc_inc -> PC + PC_INC
  5. hold
- pc_ld and pc_inc together: pc_ld wins, no increment.
- PC arithmetic: modulo 2**DATA_W; wraps silently from all-ones region to low values, no flag.
- Non-PC registers: loaded only by W0/W1; otherwise hold.
- Enables low: the corresponding address and data are don't-care; no state change.
- No X propagation: a read of a never-written register returns its reset value.

Optional Feature:
- Macro: PARAM_RF_WRITE_BYPASS_EN.
- Defined: each read port forwards same-cycle write data when its select matches an enabled write, applying the same W0-over-W1 priority. For the PC index it forwards the full PC priority result (write, pc_ld, or incremented value). pc_out stays the registered value.
- Not defined: reads return only the stored value; written data appears the cycle after the edge.

Test Plan:
- Reset with RESET_PC=0x100: assert Reset 1 cycle -> all reads 0, pc_out=0x100; a le0 write to R3 in the same cycle is ignored (R3 remains 0).
- Fill: W0 writes R0..R14 with index*0x11 on successive edges; sweep ra/rb/rc -> R5 reads 0x55, R14 reads 0xEE, each value valid the cycle after its write.
- Dual write: le0 rw0=2 pw0=0xAAAA and le1 rw1=7 pw1=0xBBBB, same edge -> R2=0xAAAA, R7=0xBBBB; next test rw0=rw1=4 with pw0=1, pw1=2 -> R4=1.
- PC priority: pc_inc -> 0x104; pc_ld with pc_in=0x200 plus pc_inc -> 0x200; le1 rw1=15 pw1=0x300 plus pc_ld -> 0x300; le0 rw0=15 pw0=0x400 plus le1 rw1=15 -> 0x400.
- Wrap: load PC=0xFFFFFFFC, pc_inc -> pc_out=0x00000000.
- Bypass (macro defined): le0 rw0=9 pw0=0x1234 with ra=9 -> puerto_a=0x1234 in the same cycle. Macro undefined: puerto_a shows the old R9 value until after the edge.
